// File: rtl/tmds_channel_decoder_if.sv
// Word-in / decoded-out bundle for one TMDS receive channel.
// slip_count is present only with TMDS_DEC_STATS_EN defined.
interface tmds_channel_decoder_if;
  logic [9:0]  tmds_word;
  logic        locked;
  logic [3:0]  bit_offset;
  logic        de;
  logic [1:0]  ctrl;
  logic [7:0]  data;
`ifdef TMDS_DEC_STATS_EN
  logic [15:0] slip_count;
`endif

  modport master (
    output tmds_word,
    input  locked, bit_offset, de, ctrl, data
`ifdef TMDS_DEC_STATS_EN
    , input slip_count
`endif
  );

  modport slave (
    input  tmds_word,
    output locked, bit_offset, de, ctrl, data
`ifdef TMDS_DEC_STATS_EN
    , output slip_count
`endif
  );
endinterface

// File: rtl/tmds_channel_decoder.sv
// TMDS channel receiver: word alignment search/monitor and decode.
// Define TMDS_DEC_STATS_EN to add the saturating slip_count counter.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT    = 16,
  parameter int SEARCH_CYCLES = 4096,
  parameter int LOSS_CYCLES   = 65536
) (
  input logic                   clock,
  input logic                   reset,
  tmds_channel_decoder_if.slave bus
);
  localparam int TMAX =
    (SEARCH_CYCLES > LOSS_CYCLES) ?
    SEARCH_CYCLES : LOSS_CYCLES;
  localparam int TW = $clog2(TMAX);
  localparam int RW = $clog2(LOCK_COUNT + 1);

  localparam logic [TW-1:0] SEARCH_LAST =
    TW'(SEARCH_CYCLES - 1);
  localparam logic [TW-1:0] LOSS_LAST =
    TW'(LOSS_CYCLES - 1);
  localparam logic [RW-1:0] RUN_FULL =
    RW'(LOCK_COUNT);

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [9:0]    prev_q, prev_d;
  logic [9:0]    aligned_q, aligned_d;
  logic [9:0]    aprev_q, aprev_d;
  logic [RW-1:0] run_q, run_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    off_q, off_d;
  logic          de_q, de_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [7:0]    data_q, data_d;

  logic [19:0] window;
  logic [19:0] shifted;
  logic        is_tok;
  logic [1:0]  tok_val;
  logic        full;
  logic        advance;
  logic [7:0]  d;
  logic [7:0]  x;
  logic [7:0]  dec;

  always_comb begin
    window    = {bus.tmds_word, prev_q};
    shifted   = window >> off_q;
    prev_d    = bus.tmds_word;
    aligned_d = shifted[9:0];
    aprev_d   = aligned_q;

    is_tok  = 1'b0;
    tok_val = 2'b00;
    unique case (1'b1)
      (aligned_q == T00): begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
      end
      (aligned_q == T01): begin
        is_tok  = 1'b1;
        tok_val = 2'b01;
      end
      (aligned_q == T10): begin
        is_tok  = 1'b1;
        tok_val = 2'b10;
      end
      (aligned_q == T11): begin
        is_tok  = 1'b1;
        tok_val = 2'b11;
      end
      default: ;
    endcase

    d   = aligned_q[9] ?
          ~aligned_q[7:0] : aligned_q[7:0];
    x   = d ^ {d[6:0], 1'b0};
    dec = {aligned_q[8] ? x[7:1] : ~x[7:1],
           d[0]};

    de_d   = ~is_tok;
    data_d = is_tok ? 8'h00 : dec;
    ctrl_d = is_tok ? tok_val : ctrl_q;

    full = (run_q == RUN_FULL);
    if (!is_tok)
      run_d = '0;
    else if (aligned_q != aprev_q)
      run_d = RW'(1);
    else if (full)
      run_d = run_q;
    else
      run_d = run_q + 1'b1;

    state_d = state_q;
    timer_d = timer_q + 1'b1;
    advance = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (full) begin
          state_d = LOCKED;
          timer_d = '0;
        end else if (timer_q == SEARCH_LAST) begin
          advance = 1'b1;
          timer_d = '0;
          run_d   = '0;
        end
      end
      LOCKED: begin
        if (full) begin
          timer_d = '0;
        end else if (timer_q == LOSS_LAST) begin
          state_d = SEARCH;
          advance = 1'b1;
          timer_d = '0;
        end
      end
      default: state_d = SEARCH;
    endcase

    off_d = off_q;
    if (advance)
      off_d = (off_q == 4'd9) ?
              4'd0 : off_q + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= SEARCH;
      prev_q    <= '0;
      aligned_q <= '0;
      aprev_q   <= '0;
      run_q     <= '0;
      timer_q   <= '0;
      off_q     <= '0;
      de_q      <= 1'b0;
      ctrl_q    <= 2'b00;
      data_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      aligned_q <= aligned_d;
      aprev_q   <= aprev_d;
      run_q     <= run_d;
      timer_q   <= timer_d;
      off_q     <= off_d;
      de_q      <= de_d;
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
    end
  end

  // Decode keeps running while unlocked; only the outputs are gated.
  assign bus.locked     = (state_q == LOCKED);
  assign bus.bit_offset = off_q;
  assign bus.de         = bus.locked & de_q;
  assign bus.ctrl       = bus.locked ? ctrl_q : 2'b00;
  assign bus.data       = bus.locked ? data_q : 8'h00;

`ifdef TMDS_DEC_STATS_EN
  logic [15:0] slip_q, slip_d;

  always_comb begin
    slip_d = slip_q;
    if (advance && slip_q != 16'hFFFF)
      slip_d = slip_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) slip_q <= '0;
    else       slip_q <= slip_d;
  end

  assign bus.slip_count = slip_q;
`endif
endmodule
